// File: rtl/imem_responder_if.sv
// Fetch bus between the IF stage (master) and the instruction memory (slave).
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch, waits WAIT_CYCLES, returns one word (or a
// fault + NOP) over a valid/ready response; flush drops in-flight work, load port fills the array.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus,
  input  logic              flush_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i,
  output logic              busy_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_instr_q, rsp_instr_d;
  logic                rsp_fault_q, rsp_fault_d;

  logic                req_ready_c;
  logic                accept_c;
  logic                load_c;
  logic                fault_c;
  logic [31:0]         rd_addr_c;
  logic [ADDR_W-1:0]   rd_idx_c;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  // Next-state, response capture and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    load_c      = 1'b0;
    rd_addr_c   = addr_q;
    rsp_instr_d = rsp_instr_q;
    rsp_fault_d = rsp_fault_q;

    req_ready_c = !flush_i && (state_q == ST_IDLE || (state_q == ST_RESP && bus.rsp_ready));
    accept_c    = bus.req_valid && req_ready_c;

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          load_c  = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A same-cycle accept in RESP overrides the return to IDLE
    if (accept_c) begin
      addr_d = bus.req_addr;
      if (WAIT_CYCLES == 0) begin
        state_d   = ST_RESP;
        load_c    = 1'b1;
        rd_addr_c = bus.req_addr;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(WAIT_CYCLES);
      end
    end

    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      load_c  = 1'b0;
    end

    fault_c  = (rd_addr_c[1:0] != 2'b00) || (rd_addr_c[31:2] >= 30'(DEPTH_WORDS));
    rd_idx_c = rd_addr_c[ADDR_W+1:2];

    if (load_c) begin
      rsp_fault_d = fault_c;
      rsp_instr_d = fault_c ? NOP_INSTR : mem[rd_idx_c];
    end

    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= NOP_INSTR;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Program-load port; a same-edge fetch capture still sees the old word
  always_ff @(posedge clk) begin
    if (ld_we_i && (32'(ld_addr_i) < DEPTH_WORDS)) mem[ld_addr_i] <= ld_data_i;
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance with no wait states, one with three.
module tb_imem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] W0     = 32'h0010_0113;
  localparam logic [31:0] W1     = 32'h0050_0093;
  localparam logic [31:0] W2     = 32'h0020_8193;
  localparam logic [31:0] WNEW   = 32'hDEAD_BEEF;

  logic              clk;
  logic              reset;
  logic              flush0, flush3;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              busy0, busy3;

  int checks;
  int errors;

  imem_responder_if if0 ();
  imem_responder_if if3 ();

  imem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .flush_i(flush0),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .busy_o(busy0)
  );

  imem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3), .flush_i(flush3),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single fetch on the zero-wait instance with rsp_ready held high
  task automatic fetch0(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_instr, input logic exp_fault);
    if0.req_valid = 1'b1;
    if0.req_addr  = addr;
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    if0.req_valid = 1'b0;
    check({tag, "_valid"}, 32'(if0.rsp_valid), 32'd1);
    check({tag, "_instr"}, if0.rsp_instr, exp_instr);
    check({tag, "_fault"}, 32'(if0.rsp_fault), 32'(exp_fault));
    @(negedge clk);
    check({tag, "_idle"}, 32'(if0.rsp_valid), 32'd0);
    if0.rsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    flush0 = 1'b0;
    flush3 = 1'b0;
    ld_we  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_addr = '0; if3.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid0", 32'(if0.rsp_valid), 32'd0);
    check("rst_instr0", if0.rsp_instr, NOP);
    check("rst_ready0", 32'(if0.req_ready), 32'd1);
    check("rst_busy0",  32'(busy0), 32'd0);
    check("rst_instr3", if3.rsp_instr, NOP);
    check("rst_fault3", 32'(if3.rsp_fault), 32'd0);

    // Load words 0..2 into both arrays
    for (int i = 0; i < 3; i++) begin
      ld_we   = 1'b1;
      ld_addr = ADDR_W'(i);
      ld_data = (i == 0) ? W0 : (i == 1) ? W1 : W2;
      @(negedge clk);
    end
    ld_we = 1'b0;

    // Zero-wait fetch with the response held for one cycle
    if0.req_valid = 1'b1;
    if0.req_addr  = 32'h4;
    if0.rsp_ready = 1'b0;
    @(negedge clk);
    if0.req_valid = 1'b0;
    check("w0_valid", 32'(if0.rsp_valid), 32'd1);
    check("w0_instr", if0.rsp_instr, W1);
    check("w0_fault", 32'(if0.rsp_fault), 32'd0);
    check("w0_busy",  32'(busy0), 32'd1);
    @(negedge clk);
    check("w0_hold", if0.rsp_instr, W1);
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    check("w0_done", 32'(if0.rsp_valid), 32'd0);
    check("w0_busy_done", 32'(busy0), 32'd0);
    if0.rsp_ready = 1'b0;

    // Three wait states: valid appears on the fourth cycle, then is held
    if3.req_valid = 1'b1;
    if3.req_addr  = 32'h8;
    if3.rsp_ready = 1'b0;
    @(negedge clk);
    if3.req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("w3_lat%0d", k), 32'(if3.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("w3_valid", 32'(if3.rsp_valid), 32'd1);
    check("w3_instr", if3.rsp_instr, W2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("w3_hold_instr%0d", k), if3.rsp_instr, W2);
      check($sformatf("w3_hold_rdy%0d", k), 32'(if3.req_ready), 32'd0);
    end
    if3.rsp_ready = 1'b1;
    #1 check("w3_rdy_on_hs", 32'(if3.req_ready), 32'd1);
    @(negedge clk);
    check("w3_done", 32'(if3.rsp_valid), 32'd0);
    check("w3_busy_done", 32'(busy3), 32'd0);
    if3.rsp_ready = 1'b0;

    // Faults: misaligned and beyond the array
    fetch0("fault_mis", 32'h2, NOP, 1'b1);
    fetch0("fault_oor", 32'h1000, NOP, 1'b1);
    fetch0("after_fault", 32'h0, W0, 1'b0);

    // Flush one cycle after accept drops the fetch entirely
    if3.req_valid = 1'b1;
    if3.req_addr  = 32'h8;
    @(negedge clk);
    if3.req_valid = 1'b0;
    flush3 = 1'b1;
    #1 check("fl_rdy", 32'(if3.req_ready), 32'd0);
    check("fl_busy", 32'(busy3), 32'd1);
    @(negedge clk);
    flush3 = 1'b0;
    check("fl_idle", 32'(busy3), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fl_novalid%0d", k), 32'(if3.rsp_valid), 32'd0);
      @(negedge clk);
    end
    if3.req_valid = 1'b1;
    if3.req_addr  = 32'h0;
    if3.rsp_ready = 1'b1;
    @(negedge clk);
    if3.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("fl_new_valid", 32'(if3.rsp_valid), 32'd1);
    check("fl_new_instr", if3.rsp_instr, W0);
    @(negedge clk);
    if3.rsp_ready = 1'b0;

    // Streaming: one response per cycle, in order
    if0.rsp_ready = 1'b1;
    if0.req_valid = 1'b1;
    if0.req_addr  = 32'h0;
    @(negedge clk);
    check("st0_valid", 32'(if0.rsp_valid), 32'd1);
    check("st0_instr", if0.rsp_instr, W0);
    check("st0_rdy",   32'(if0.req_ready), 32'd1);
    if0.req_addr = 32'h4;
    @(negedge clk);
    check("st1_valid", 32'(if0.rsp_valid), 32'd1);
    check("st1_instr", if0.rsp_instr, W1);
    if0.req_addr = 32'h8;
    @(negedge clk);
    check("st2_valid", 32'(if0.rsp_valid), 32'd1);
    check("st2_instr", if0.rsp_instr, W2);
    if0.req_valid = 1'b0;
    @(negedge clk);
    check("st_end", 32'(if0.rsp_valid), 32'd0);
    if0.rsp_ready = 1'b0;

    // Load and fetch capture of the same word on one edge: old data returned
    ld_we   = 1'b1;
    ld_addr = '0;
    ld_data = WNEW;
    if0.req_valid = 1'b1;
    if0.req_addr  = 32'h0;
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
    if0.req_valid = 1'b0;
    check("col_old", if0.rsp_instr, W0);
    @(negedge clk);
    if0.rsp_ready = 1'b0;
    fetch0("col_new", 32'h0, WNEW, 1'b0);

    // Reset in the middle of a fetch
    if3.req_valid = 1'b1;
    if3.req_addr  = 32'h4;
    @(negedge clk);
    if3.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rmid_busy",  32'(busy3), 32'd0);
    check("rmid_valid", 32'(if3.rsp_valid), 32'd0);
    check("rmid_instr", if3.rsp_instr, NOP);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rmid_never", 32'(if3.rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
